// File: rtl/wb_dbg_pkg.sv
// Shared definitions for the PCI debug counter poll master: sequencer states,
// debug slave word map and clear-bit layout of the control word.
package wb_dbg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_GAP,
        S_WR_CLR,
        S_WR_GAP,
        S_FIN
    } dbg_state_e;

    // Word indices of the debug slave (byte address = base + index*4)
    localparam int unsigned DBG_CTRL_W         = 0;
    localparam int unsigned DBG_FRAME_DEVSEL_W = 1;
    localparam int unsigned DBG_IRDY_TRDY_W    = 2;
    localparam int unsigned DBG_STOP_IDSEL_W   = 3;
    localparam int unsigned DBG_GNT_REQ_W      = 4;
    localparam int unsigned DBG_PAR_PERR_W     = 5;

    // Clear bits live in the control word, bit positions 0..9
    localparam int unsigned DBG_CLR_BIT_FIRST  = 0;
    localparam int unsigned DBG_CLR_BIT_LAST   = 9;
    localparam int unsigned DBG_CLR_NBITS      = DBG_CLR_BIT_LAST - DBG_CLR_BIT_FIRST + 1;

    // Byte address of a debug slave word
    function automatic logic [31:0] dbg_word_addr(input logic [31:0] base,
                                                  input logic [31:0] word);
        return base + (word << 2);
    endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// Single Wishbone transfer engine: drives STB/WE while requested and reports
// completion (matching response type) or timeout after TIMEOUT strobe cycles.
module wb_single_xfer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic we_i,
    input  logic ack_i,
    input  logic valid_i,
    output logic stb_o,
    output logic we_o,
    output logic done_o,
    output logic timed_out_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       resp;

    // Response qualification, strobe drive and timeout detection; a response
    // in the final counted cycle takes priority over the timeout
    always_comb begin
        resp        = we_i ? ack_i : valid_i;
        stb_o       = req_i;
        we_o        = req_i & we_i;
        done_o      = req_i & resp;
        timed_out_o = req_i & ~resp & (cnt_q == CNT_LAST);
        if (!req_i || done_o || timed_out_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Strobe-cycle counter, idle at zero between transfers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_dbg_poll_master.sv
// Debug counter poll master: reads NUM_REGS consecutive slave words into a
// snapshot file, optionally writes the clear mask to the control word, and
// exposes the snapshots through an indexed combinational read port.
module wb_dbg_poll_master
    import wb_dbg_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned NUM_REGS  = 5,
    parameter int unsigned TIMEOUT   = 15,
    parameter logic [9:0]  CLR_MASK  = 10'h3FF
) (
    input  logic        PHY_CLK33_I,
    input  logic        PHY_RSTn_I,
    input  logic        START_I,
    input  logic        CLR_EN_I,
    output logic        BUSY_O,
    output logic        DONE_O,
    output logic        ERR_O,
    output logic [7:0]  TO_MASK_O,
    input  logic [2:0]  SNAP_SEL_I,
    output logic [31:0] SNAP_DATA_O,
    output logic [31:0] WB_ADD_O,
    output logic [31:0] WB_DATA_O,
    input  logic [31:0] WB_DATA_I,
    output logic        WB_STB_O,
    output logic        WB_WE_O,
    input  logic        WB_ACK_I,
    input  logic        WB_VALID_I
);

    localparam logic [2:0]  LAST_IDX = 3'(NUM_REGS - 1);
    localparam logic [31:0] CLR_DATA = {{(32 - DBG_CLR_NBITS){1'b0}}, CLR_MASK};

    dbg_state_e  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        clr_q, clr_d;
    logic        err_q, err_d;
    logic [7:0]  tomask_q, tomask_d;
    logic [31:0] snap_q [NUM_REGS];
    logic [31:0] snap_d [NUM_REGS];

    logic        xfer_req, xfer_we, xfer_done, xfer_to;
    logic [31:0] add, wdata;

    wb_single_xfer #(
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk_i       (PHY_CLK33_I),
        .rst_ni      (PHY_RSTn_I),
        .req_i       (xfer_req),
        .we_i        (xfer_we),
        .ack_i       (WB_ACK_I),
        .valid_i     (WB_VALID_I),
        .stb_o       (WB_STB_O),
        .we_o        (WB_WE_O),
        .done_o      (xfer_done),
        .timed_out_o (xfer_to)
    );

    // Sequencer next-state, snapshot updates and bus request decode
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_d    = clr_q;
        err_d    = err_q;
        tomask_d = tomask_q;
        snap_d   = snap_q;
        xfer_req = 1'b0;
        xfer_we  = 1'b0;
        add      = '0;
        wdata    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (START_I) begin
                    clr_d    = CLR_EN_I;
                    err_d    = 1'b0;
                    tomask_d = '0;
                    idx_d    = '0;
                    state_d  = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                xfer_req = 1'b1;
                add      = dbg_word_addr(ADDR_BASE, FIRST_REG + 32'(idx_q));
                if (xfer_done) begin
                    snap_d[idx_q] = WB_DATA_I;
                    state_d       = S_RD_GAP;
                end else if (xfer_to) begin
                    snap_d[idx_q]   = '0;
                    tomask_d[idx_q] = 1'b1;
                    err_d           = 1'b1;
                    state_d         = S_RD_GAP;
                end
            end
            S_RD_GAP: begin
                // Terminal test on the index itself so NUM_REGS=8 never wraps
                if (idx_q == LAST_IDX) begin
                    state_d = clr_q ? S_WR_CLR : S_FIN;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_RD_REQ;
                end
            end
            S_WR_CLR: begin
                xfer_req = 1'b1;
                xfer_we  = 1'b1;
                add      = dbg_word_addr(ADDR_BASE, 32'(DBG_CTRL_W));
                wdata    = CLR_DATA;
                if (xfer_done) begin
                    state_d = S_WR_GAP;
                end else if (xfer_to) begin
                    err_d   = 1'b1;
                    state_d = S_WR_GAP;
                end
            end
            S_WR_GAP: state_d = S_FIN;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Sequencer state, status and snapshot registers
    always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
        if (!PHY_RSTn_I) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            clr_q    <= 1'b0;
            err_q    <= 1'b0;
            tomask_q <= '0;
            snap_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            clr_q    <= clr_d;
            err_q    <= err_d;
            tomask_q <= tomask_d;
            snap_q   <= snap_d;
        end
    end

    // Indexed snapshot read; unimplemented indices read as zero
    always_comb begin
        SNAP_DATA_O = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (SNAP_SEL_I == 3'(i)) begin
                SNAP_DATA_O = snap_q[i];
            end
        end
    end

    assign WB_ADD_O  = add;
    assign WB_DATA_O = wdata;
    assign BUSY_O    = (state_q != S_IDLE);
    assign DONE_O    = (state_q == S_FIN);
    assign ERR_O     = err_q;
    assign TO_MASK_O = tomask_q;

endmodule

// File: tb/tb_wb_dbg_poll_master.sv
// Directed bench for wb_dbg_poll_master with a zero-wait debug slave model
// whose response mode can be switched per scenario.
module tb_wb_dbg_poll_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clr_en = 1'b0;
    logic        busy, done, err;
    logic [7:0]  to_mask;
    logic [2:0]  snap_sel = '0;
    logic [31:0] snap_data;
    logic [31:0] wb_add, wb_dout, wb_din;
    logic        wb_stb, wb_we, wb_ack, wb_valid;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave behaviour controls
    logic [9:0] silent_word = 10'h3FF;
    logic       rd_use_ack = 1'b0;
    logic       wr_use_valid = 1'b0;

    // Monitor results
    int          wr_cnt = 0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    logic        post_pending = 1'b0;
    logic        post_stb = 1'b1;
    logic [31:0] post_data = '1;
    int          stb3_cnt = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    wb_dbg_poll_master #(
        .ADDR_BASE (32'h0000_0000),
        .FIRST_REG (1),
        .NUM_REGS  (5),
        .TIMEOUT   (15),
        .CLR_MASK  (10'h3FF)
    ) dut (
        .PHY_CLK33_I (clk),
        .PHY_RSTn_I  (rst_n),
        .START_I     (start),
        .CLR_EN_I    (clr_en),
        .BUSY_O      (busy),
        .DONE_O      (done),
        .ERR_O       (err),
        .TO_MASK_O   (to_mask),
        .SNAP_SEL_I  (snap_sel),
        .SNAP_DATA_O (snap_data),
        .WB_ADD_O    (wb_add),
        .WB_DATA_O   (wb_dout),
        .WB_DATA_I   (wb_din),
        .WB_STB_O    (wb_stb),
        .WB_WE_O     (wb_we),
        .WB_ACK_I    (wb_ack),
        .WB_VALID_I  (wb_valid)
    );

    // Zero-wait slave: responds during the strobe cycle, sampled at the next edge
    always_comb begin
        wb_din   = '0;
        wb_ack   = 1'b0;
        wb_valid = 1'b0;
        if (wb_stb) begin
            if (!wb_we) begin
                if (wb_add[11:2] != silent_word) begin
                    wb_din = 32'h0001_0002 + {22'b0, wb_add[11:2]};
                    if (rd_use_ack) wb_ack = 1'b1;
                    else            wb_valid = 1'b1;
                end
            end else begin
                if (wr_use_valid) wb_valid = 1'b1;
                else              wb_ack = 1'b1;
            end
        end
    end

    // Bus monitor sampled mid-cycle
    always @(negedge clk) begin
        if (post_pending) begin
            post_stb     = wb_stb;
            post_data    = wb_dout;
            post_pending = 1'b0;
        end
        if (wb_stb && wb_we && wb_ack) begin
            wr_cnt++;
            wr_addr      = wb_add;
            wr_data      = wb_dout;
            post_pending = 1'b1;
        end
        if (wb_stb && !wb_we && wb_add[11:2] == 10'd3) stb3_cnt++;
        if (done) done_cnt++;
    end

    // Pulse START, then count cycles (cycle 1 = first cycle after the start edge)
    // until DONE_O; optionally re-pulse START at cycle restart_at. 0 = no DONE.
    task automatic run_seq(input logic clr, input int restart_at, output int done_cyc);
        @(negedge clk);
        start  = 1'b1;
        clr_en = clr;
        @(posedge clk);
        #1;
        start    = 1'b0;
        clr_en   = 1'b0;
        done_cyc = 0;
        for (int c = 1; c <= 300; c++) begin
            if (c == restart_at + 1) start = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (c == restart_at) start = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic check_snaps(input string name, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e4);
        logic [31:0] exp_v [8];
        exp_v = '{e0, e1, e2, e3, e4, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            snap_sel = 3'(i);
            #1;
            n_cmp++;
            if (snap_data !== exp_v[i]) begin
                n_bad++;
                $display("FAIL %s snap[%0d]: got %h expected %h", name, i, snap_data, exp_v[i]);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({busy, done, err, to_mask, wb_stb, wb_we} !== 13'b0 || wb_add !== 32'h0 || wb_dout !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b mask=%h stb=%b we=%b add=%h dat=%h expected all 0",
                     busy, done, err, to_mask, wb_stb, wb_we, wb_add, wb_dout);
        end
        check_snaps("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_only();
        int dc, w0;
        w0 = wr_cnt;
        run_seq(1'b0, 0, dc);
        n_cmp++;
        if (dc !== 11) begin n_bad++; $display("FAIL rd_done_cycle: got %0d expected 11", dc); end
        n_cmp++;
        if (wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL rd_no_write: got %0d writes expected 0", wr_cnt - w0); end
        n_cmp++;
        if (err !== 1'b0 || to_mask !== 8'h00) begin
            n_bad++; $display("FAIL rd_status: err=%b mask=%h expected 0/00", err, to_mask);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL rd_idle_after: busy=%b done=%b expected 0/0", busy, done);
        end
        check_snaps("rd", 32'h0001_0003, 32'h0001_0004, 32'h0001_0005, 32'h0001_0006, 32'h0001_0007);
    endtask

    task automatic test_clear_write();
        int dc, w0;
        w0 = wr_cnt;
        run_seq(1'b1, 0, dc);
        @(negedge clk);
        n_cmp++;
        if (dc !== 13) begin n_bad++; $display("FAIL clr_done_cycle: got %0d expected 13", dc); end
        n_cmp++;
        if (wr_cnt - w0 !== 1 || wr_addr !== 32'h0 || wr_data !== 32'h0000_03FF) begin
            n_bad++; $display("FAIL clr_write: count=%0d addr=%h data=%h expected 1/00000000/000003ff",
                              wr_cnt - w0, wr_addr, wr_data);
        end
        n_cmp++;
        if (post_stb !== 1'b0 || post_data !== 32'h0) begin
            n_bad++; $display("FAIL clr_gap: stb=%b data=%h expected 0/00000000", post_stb, post_data);
        end
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL clr_err: got %b expected 0", err); end
    endtask

    task automatic test_timeout_word3();
        int dc, s0;
        s0 = stb3_cnt;
        silent_word = 10'd3;
        run_seq(1'b0, 0, dc);
        silent_word = 10'h3FF;
        n_cmp++;
        if (dc !== 25) begin n_bad++; $display("FAIL to_done_cycle: got %0d expected 25", dc); end
        n_cmp++;
        if (stb3_cnt - s0 !== 15) begin n_bad++; $display("FAIL to_stb_cycles: got %0d expected 15", stb3_cnt - s0); end
        n_cmp++;
        if (to_mask !== 8'h04 || err !== 1'b1) begin
            n_bad++; $display("FAIL to_status: mask=%h err=%b expected 04/1", to_mask, err);
        end
        check_snaps("to", 32'h0001_0003, 32'h0001_0004, 32'h0, 32'h0001_0006, 32'h0001_0007);
    endtask

    task automatic test_wrong_response();
        int dc;
        rd_use_ack = 1'b1;
        run_seq(1'b0, 0, dc);
        rd_use_ack = 1'b0;
        n_cmp++;
        if (dc !== 81) begin n_bad++; $display("FAIL rdack_done_cycle: got %0d expected 81", dc); end
        n_cmp++;
        if (to_mask !== 8'h1F || err !== 1'b1) begin
            n_bad++; $display("FAIL rdack_status: mask=%h err=%b expected 1f/1", to_mask, err);
        end
        check_snaps("rdack", 0, 0, 0, 0, 0);
        wr_use_valid = 1'b1;
        run_seq(1'b1, 0, dc);
        wr_use_valid = 1'b0;
        n_cmp++;
        if (dc !== 27) begin n_bad++; $display("FAIL wrvalid_done_cycle: got %0d expected 27", dc); end
        n_cmp++;
        if (to_mask !== 8'h00 || err !== 1'b1) begin
            n_bad++; $display("FAIL wrvalid_status: mask=%h err=%b expected 00/1", to_mask, err);
        end
        check_snaps("wrvalid", 32'h0001_0003, 32'h0001_0004, 32'h0001_0005, 32'h0001_0006, 32'h0001_0007);
    endtask

    task automatic test_back_to_back_start();
        int dc, d0;
        d0 = done_cnt;
        run_seq(1'b0, 4, dc);
        n_cmp++;
        if (err !== 1'b0 || to_mask !== 8'h00) begin
            n_bad++; $display("FAIL restart_cleared: err=%b mask=%h expected 0/00", err, to_mask);
        end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (dc !== 11) begin n_bad++; $display("FAIL restart_done_cycle: got %0d expected 11", dc); end
        n_cmp++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL restart_single_done: dones=%0d busy=%b expected 1/0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_async_reset();
        int dc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        n_cmp++;
        if (wb_stb !== 1'b1 || wb_add !== 32'h0000_000C) begin
            n_bad++; $display("FAIL rst_pre_stb: stb=%b add=%h expected 1/0000000c", wb_stb, wb_add);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (wb_stb !== 1'b0 || busy !== 1'b0 || wb_add !== 32'h0) begin
            n_bad++; $display("FAIL rst_async_drop: stb=%b busy=%b add=%h expected 0/0/0", wb_stb, busy, wb_add);
        end
        check_snaps("rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(1'b0, 0, dc);
        n_cmp++;
        if (dc !== 11 || err !== 1'b0) begin
            n_bad++; $display("FAIL rst_recover: done_cycle=%0d err=%b expected 11/0", dc, err);
        end
        check_snaps("rst_rec", 32'h0001_0003, 32'h0001_0004, 32'h0001_0005, 32'h0001_0006, 32'h0001_0007);
    endtask

    initial begin
        test_reset();
        test_read_only();
        test_clear_write();
        test_timeout_word3();
        test_wrong_response();
        test_back_to_back_start();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_dbg_poll_master.md
Name: wb_dbg_poll_master

Overview:
Wishbone master that drives the PCI debug counter slave from the opposite end of the bus. On a start pulse it reads each counter word in turn and latches the results into a local snapshot file. It can then issue one clear write to the slave's control word (word 0). It sits beside the debug slave on the 33 MHz PHY clock and exposes the snapshots through a simple indexed read port for the host-side logic.

Parameters:
ADDR_BASE, 32'h0000_0000, byte base address of the debug slave
FIRST_REG, 1, first word index read (WB_ADD_O[11:2])
NUM_REGS, 5, number of consecutive words read (1..8)
TIMEOUT, 15, cycles to wait for VALID/ACK after STB assertion (1..255)
CLR_MASK, 10'h3FF, data written to word 0 during the clear phase

Ports:
PHY_CLK33_I  in  1  clock
PHY_RSTn_I  in  1  asynchronous active-low reset
START_I  in  1  single-cycle pulse: begin poll sequence
CLR_EN_I  in  1  sampled with START_I; 1 = perform clear write after reads
BUSY_O  out  1  sequence in progress
DONE_O  out  1  one-cycle pulse when sequence completes
ERR_O  out  1  sticky: any timeout in the last sequence; cleared on next START_I
TO_MASK_O  out  8  per-snapshot timeout flags for the last sequence
SNAP_SEL_I  in  3  snapshot index
SNAP_DATA_O  out  32  snapshot[SNAP_SEL_I], combinational read; 0 if index >= NUM_REGS
WB_ADD_O  out  32  address
WB_DATA_O  out  32  write data
WB_DATA_I  in  32  read data
WB_STB_O  out  1  strobe
WB_WE_O  out  1  1 = write
WB_ACK_I  in  1  write acknowledge
WB_VALID_I  in  1  read data valid

Behaviour:
- Clock PHY_CLK33_I; reset PHY_RSTn_I is asynchronous, active-low.
- Reset values: all WB outputs 0, BUSY_O 0, DONE_O 0, ERR_O 0, TO_MASK_O 0, snapshots 0, state IDLE.
- Reset mid-transaction drops WB_STB_O immediately, without waiting for a clock edge. No partial results are retained.
- States:
  - IDLE: START_I=1 captures CLR_EN_I, clears ERR_O and TO_MASK_O, sets idx=0, goes to RD_REQ.
  - RD_REQ: STB=1, WE=0, ADD=ADDR_BASE+((FIRST_REG+idx)<<2). The timeout counter starts at 0 and increments each cycle.
    - WB_VALID_I=1: snapshot[idx]<=WB_DATA_I, go to RD_GAP.
    - Counter reaches TIMEOUT first: snapshot[idx]<=0, TO_MASK_O[idx]<=1, ERR_O<=1, go to RD_GAP.
  - RD_GAP: STB=0 for exactly one cycle (the slave resets its response when STB is low). Then idx+1 goes to RD_REQ if idx<NUM_REGS-1. Otherwise go to WR_CLR if the clear was captured, else FIN.
  - WR_CLR: STB=1, WE=1, ADD=ADDR_BASE, WB_DATA_O={22'b0,CLR_MASK}.
    - WB_ACK_I=1: go to WR_GAP.
    - Timeout: ERR_O<=1, go to WR_GAP. No TO_MASK bit is set.
  - WR_GAP: STB=0 and WB_DATA_O=0 for one cycle, which releases the slave's clear bits. Then go to FIN.
  - FIN: DONE_O=1 for one cycle, then IDLE.
- BUSY_O=1 in every state except IDLE.
- START_I while BUSY_O=1 is ignored.
- Only WB_VALID_I is honoured when WE=0, and only WB_ACK_I when WE=1. The wrong-type response is ignored and counts toward timeout.
- VALID/ACK arriving in the same cycle the timeout expires: the response wins and no error is recorded.
- Minimum read latency with a 1-cycle slave is 2 cycles/word (REQ+GAP).
- Full sequence with NUM_REGS=5 and clear: 5×2+2+1 = 13 cycles from START to DONE.
- Snapshots hold their values until overwritten by the next sequence, and remain readable while busy.
- The idx counter is 3 bits. NUM_REGS=8 must terminate correctly with no wrap to 0.

Decomposition:
- Shared package wb_dbg_pkg: FSM state enum (IDLE, RD_REQ, RD_GAP, WR_CLR, WR_GAP, FIN).
- Same package: word index constants DBG_CTRL_W=0, DBG_FRAME_DEVSEL_W=1, DBG_IRDY_TRDY_W=2, DBG_STOP_IDSEL_W=3, DBG_GNT_REQ_W=4, DBG_PAR_PERR_W=5, plus the clear-bit positions 0..9.
- One sub-module, wb_single_xfer: owns STB/WE/timeout for one transfer, with the interface req, we, done, timed_out.
- The top holds the sequencer and the snapshot file.

Test Plan:
- Slave model returns 32'h0001_0002 + word index one cycle after STB; START with CLR_EN=0 -> snapshots {…0003, …0004, …0005, …0006, …0007}, DONE at cycle 11, no write issued, ERR_O=0.
- START with CLR_EN=1 -> one write to address 0 with data 32'h0000_03FF, ACK seen, STB low the following cycle with data 0, DONE at cycle 13.
- Slave silent for word 3 -> STB held exactly 15 cycles, then dropped; snapshot[2]=0, TO_MASK_O=8'h04, ERR_O=1. The other words are read normally.
- Slave answers a read with ACK instead of VALID -> ignored and times out; a write answered with VALID also times out with ERR_O=1 and TO_MASK unchanged.
- START pulsed again at cycle 4 of a sequence -> ignored, a single DONE only. A new START then clears ERR_O/TO_MASK_O.
- PHY_RSTn_I asserted low while STB=1 in word 2 -> STB and BUSY go 0 without a clock edge, snapshots 0. The next START completes normally.
